// File: rtl/s_mem_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// s_mem_checker
// Reader/verifier for the S memory that the init block fills with s[i]=i.
// After a start handshake it scans every address of the RAM in order, one
// read per cycle, and compares each returned byte with its own address.
// It reports pass/fail, the number of mismatching words and the first bad
// address. The RAM is only ever read from this block.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   en         start request, sampled only while rdy=1
//   rdy        1 = idle and able to accept en
//   addr       RAM read address
//   rddata     RAM read data, valid RD_LAT cycles after addr
//   done       one-cycle pulse when a scan completes
//   pass       1 = no mismatches in the last completed scan
//   err_count  number of mismatching words (0..DEPTH)
//   err_addr   address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module s_mem_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Expected content is the identity map: the low data bits of the address.
  function automatic logic word_mismatch(input logic [DATA_W-1:0] data,
                                         input logic [ADDR_W-1:0] tag);
    return (data != DATA_W'(tag));
  endfunction

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADDR_W:0]     err_count_q, err_count_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                first_seen_q, first_seen_d;
  // Tag pipeline: each issued address travels alongside its outstanding read
  // so the compare sees the address that produced the current rddata.
  logic                pipe_vld_q [RD_LAT];
  logic                pipe_vld_d [RD_LAT];
  logic [ADDR_W-1:0]   pipe_tag_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_tag_d [RD_LAT];
  logic                cmp_vld_s;
  logic [ADDR_W-1:0]   cmp_tag_s;

  assign cmp_vld_s = pipe_vld_q[RD_LAT-1];
  assign cmp_tag_s = pipe_tag_q[RD_LAT-1];

  // Next-state logic: scan FSM, tag pipeline shift and mismatch accounting.
  always_comb begin
    state_d      = state_q;
    rdy_d        = rdy_q;
    addr_d       = addr_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    err_addr_d   = err_addr_q;
    first_seen_d = first_seen_q;

    // A tag enters only for cycles where READ is driving a fresh address.
    pipe_vld_d[0] = (state_q == S_READ);
    pipe_tag_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end

    if (cmp_vld_s && word_mismatch(rddata, cmp_tag_s)) begin
      err_count_d = err_count_q + {{ADDR_W{1'b0}}, 1'b1};
      if (!first_seen_q) begin
        err_addr_d   = cmp_tag_s;
        first_seen_d = 1'b1;
      end else begin
        err_addr_d   = err_addr_q;
        first_seen_d = first_seen_q;
      end
    end else begin
      err_count_d = err_count_q;
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          rdy_d        = 1'b0;
          addr_d       = {ADDR_W{1'b0}};
          err_count_d  = {(ADDR_W+1){1'b0}};
          err_addr_d   = {ADDR_W{1'b0}};
          pass_d       = 1'b0;
          first_seen_d = 1'b0;
          state_d      = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // addr stops at the last word instead of wrapping.
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        // Finish on the edge that compares the last tag; pass folds in that
        // final comparison via err_count_d.
        if (cmp_vld_s && (cmp_tag_s == LAST_ADDR)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_count_d == {(ADDR_W+1){1'b0}});
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset that aborts any scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rdy_q        <= 1'b1;
      addr_q       <= {ADDR_W{1'b0}};
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= {(ADDR_W+1){1'b0}};
      err_addr_q   <= {ADDR_W{1'b0}};
      first_seen_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      err_addr_q   <= err_addr_d;
      first_seen_q <= first_seen_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_tag_q[i] <= pipe_tag_d[i];
      end
    end
  end

  assign rdy       = rdy_q;
  assign addr      = addr_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_s_mem_checker.sv
`timescale 1ns/1ps
// Directed bench for s_mem_checker: instance A uses a 1-cycle RAM, instance B
// a 2-cycle RAM. Each has its own behavioural RAM model.
module tb_s_mem_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, en_b;
  logic        rdy_a, rdy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0]  addr_a, addr_b, err_addr_a, err_addr_b;
  logic [8:0]  err_count_a, err_count_b;
  logic [7:0]  rd_a, rd_b, rd_b1;
  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];

  s_mem_checker #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .addr(addr_a),
    .rddata(rd_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .err_addr(err_addr_a)
  );

  s_mem_checker #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .addr(addr_b),
    .rddata(rd_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .err_addr(err_addr_b)
  );

  // Registered-read RAM models: one stage for A, two for B.
  always @(posedge clk) rd_a <= mem_a[addr_a];
  always @(posedge clk) begin
    rd_b1 <= mem_b[addr_b];
    rd_b  <= rd_b1;
  end

  logic       sel;
  logic       rdy_m, done_m;
  logic [7:0] addr_m;
  always_comb begin
    rdy_m  = sel ? rdy_b  : rdy_a;
    done_m = sel ? done_b : done_a;
    addr_m = sel ? addr_b : addr_a;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Start one scan and watch it; cycle numbers count posedges after the
  // accepting edge (accepting edge = 0).
  task automatic run_scan(input logic use_b, input logic hold_en,
                          output int done_cyc, output int rdy_cyc,
                          output int pulses, output logic [7:0] addr_at_done);
    sel = use_b;
    @(negedge clk);
    if (use_b) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk); #1;
    check_eq("accept_rdy_low", {31'd0, rdy_m}, 32'd0);
    if (!hold_en) begin
      en_a = 1'b0;
      en_b = 1'b0;
    end
    done_cyc = -1; rdy_cyc = -1; pulses = 0; addr_at_done = 8'h00;
    for (int c = 1; c <= 400 && rdy_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (done_m) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          addr_at_done = addr_m;
        end
      end
      if (rdy_m) rdy_cyc = c;
    end
  endtask

  task automatic wait_idle_a();
    for (int c = 0; c < 400 && !rdy_a; c++) begin
      @(posedge clk); #1;
    end
  endtask

  int         dc, rc, np;
  logic [7:0] ad;

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_rdy",       {31'd0, rdy_a},      32'd1);
    check_eq("rst_addr",      {24'd0, addr_a},     32'd0);
    check_eq("rst_done",      {31'd0, done_a},     32'd0);
    check_eq("rst_pass",      {31'd0, pass_a},     32'd0);
    check_eq("rst_err_count", {23'd0, err_count_a}, 32'd0);
    check_eq("rst_err_addr",  {24'd0, err_addr_a}, 32'd0);

    // 1: identity RAM
    run_scan(1'b0, 1'b0, dc, rc, np, ad);
    check_eq("t1_done_cycle", dc, 32'd257);
    check_eq("t1_rdy_cycle",  rc, 32'd258);
    check_eq("t1_pulses",     np, 32'd1);
    check_eq("t1_addr_hold",  {24'd0, ad}, 32'd255);
    check_eq("t1_pass",       {31'd0, pass_a}, 32'd1);
    check_eq("t1_err_count",  {23'd0, err_count_a}, 32'd0);
    check_eq("t1_err_addr",   {24'd0, err_addr_a}, 32'd0);

    // 2: two corrupted words
    mem_a[8'h37] = 8'h00;
    mem_a[8'hC2] = 8'hFF;
    run_scan(1'b0, 1'b0, dc, rc, np, ad);
    check_eq("t2_pass",      {31'd0, pass_a}, 32'd0);
    check_eq("t2_err_count", {23'd0, err_count_a}, 32'd2);
    check_eq("t2_err_addr",  {24'd0, err_addr_a}, 32'h37);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t2_hold_count", {23'd0, err_count_a}, 32'd2);

    // 3: all-zero RAM
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    run_scan(1'b0, 1'b0, dc, rc, np, ad);
    check_eq("t3_pass",      {31'd0, pass_a}, 32'd0);
    check_eq("t3_err_count", {23'd0, err_count_a}, 32'd255);
    check_eq("t3_err_addr",  {24'd0, err_addr_a}, 32'h01);

    // 4: en held high through the scan
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
    run_scan(1'b0, 1'b1, dc, rc, np, ad);
    check_eq("t4_pulses",    np, 32'd1);
    check_eq("t4_rdy_cycle", rc, 32'd258);
    @(posedge clk); #1;
    check_eq("t4_restart_rdy", {31'd0, rdy_a}, 32'd0);
    en_a = 1'b0;
    wait_idle_a();
    check_eq("t4_second_pass", {31'd0, pass_a}, 32'd1);

    // 5: reset mid-scan at addr 0x80
    mem_a[5] = 8'h00;
    sel = 1'b0;
    @(negedge clk); en_a = 1'b1;
    @(posedge clk); #1; en_a = 1'b0;
    for (int c = 0; c < 400 && addr_a != 8'h80; c++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_reached_80", {24'd0, addr_a}, 32'h80);
    check_eq("t5_pre_count",  {23'd0, err_count_a}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rdy",       {31'd0, rdy_a}, 32'd1);
    check_eq("t5_addr",      {24'd0, addr_a}, 32'd0);
    check_eq("t5_err_count", {23'd0, err_count_a}, 32'd0);
    check_eq("t5_err_addr",  {24'd0, err_addr_a}, 32'd0);
    check_eq("t5_done",      {31'd0, done_a}, 32'd0);
    mem_a[5] = 8'h05;
    @(negedge clk); rst = 1'b0;
    run_scan(1'b0, 1'b0, dc, rc, np, ad);
    check_eq("t5_after_pass", {31'd0, pass_a}, 32'd1);

    // 6: two-cycle RAM, mismatch on the last word
    mem_b[8'hFF] = 8'h00;
    run_scan(1'b1, 1'b0, dc, rc, np, ad);
    check_eq("t6_done_cycle", dc, 32'd258);
    check_eq("t6_rdy_cycle",  rc, 32'd259);
    check_eq("t6_err_addr",   {24'd0, err_addr_b}, 32'hFF);
    check_eq("t6_err_count",  {23'd0, err_count_b}, 32'd1);
    check_eq("t6_pass",       {31'd0, pass_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
